encoder_4x2_reg: RTL

//   Registered priority encoder with a valid/ready handshake. It is the inverse of the 2x4 decoder
//   in the Decoders library: it turns a 4-bit request vector into a 2-bit index plus a valid flag.
//   A one-entry output register absorbs downstream stalls. A saturating counter records every

---
 rtl/encoder_4x2_reg_if.sv | 29 ++
 rtl/encoder_4x2_reg.sv | 91 +++++++++
 2 files changed

// File: rtl/encoder_4x2_reg_if.sv
// Handshake bundle for the registered priority encoder: request side, result side and debug counter.
// The encoder itself connects through the slave modport.
interface encoder_4x2_reg_if #(
  parameter int N_IN      = 4,
  parameter int W_OUT     = 2,
  parameter int ERR_CNT_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [N_IN-1:0]      I;
  logic                 En;
  logic                 out_valid;
  logic                 out_ready;
  logic [W_OUT-1:0]     Y;
  logic                 V;
  logic                 multi;
  logic                 err_clr;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output in_valid, I, En, out_ready, err_clr,
    input  in_ready, out_valid, Y, V, multi, err_cnt
  );

  modport slave (
    input  in_valid, I, En, out_ready, err_clr,
    output in_ready, out_valid, Y, V, multi, err_cnt
  );
endinterface

// File: rtl/encoder_4x2_reg.sv
// Registered MSB-priority encoder behind a one-entry valid/ready output stage,
// with a saturating count of accepted multi-hot requests.
module encoder_4x2_reg #(
  parameter int N_IN      = 4,
  parameter int W_OUT     = 2,
  parameter int ERR_CNT_W = 8
) (
  input logic              clk,
  input logic              rst,
  encoder_4x2_reg_if.slave bus
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e               state_q, state_d;
  logic [W_OUT-1:0]     y_q, y_d;
  logic                 v_q, v_d;
  logic                 multi_q, multi_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [W_OUT-1:0]     enc_y;
  logic                 enc_v;
  logic                 enc_multi;
  logic                 in_ready;
  logic                 accept;

  // Later iterations overwrite earlier ones, so the highest set bit wins.
  // NOTE: every variable assigned in always_comb gets a default first; a missing default infers a latch.
  always_comb begin
    enc_y = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (bus.I[i]) enc_y = W_OUT'(i);
    end
    if (!bus.En) enc_y = '0;
    enc_v     = bus.En & (|bus.I);
    // x & (x-1) clears the lowest set bit; anything left means two or more bits were set.
    enc_multi = bus.En & (|(bus.I & (bus.I - N_IN'(1))));
  end

  // in_ready depends only on state and out_ready, never on in_valid.
  assign in_ready = (state_q == EMPTY) | bus.out_ready;
  assign accept   = bus.in_valid & in_ready;

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    v_d       = v_q;
    multi_d   = multi_q;
    err_cnt_d = err_cnt_q;

    if (accept) begin
      state_d = FULL;
      y_d     = enc_y;
      v_d     = enc_v;
      multi_d = enc_multi;
    end else if (bus.out_ready) begin
      state_d = EMPTY;
    end

    if (bus.err_clr) begin
      err_cnt_d = '0;
    end else if (accept && enc_multi && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      y_q       <= '0;
      v_q       <= 1'b0;
      multi_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      v_q       <= v_d;
      multi_q   <= multi_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == FULL);
  assign bus.Y         = y_q;
  assign bus.V         = v_q;
  assign bus.multi     = multi_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule
